minterm_sweeper: RTL and testbench

Sequential sweep controller that drives the x1..x4 inputs of the lab's 4-input combinational function blocks (the q2 family) and consumes their output f.
It steps through all 16 minterms in order, holds each for a settle window, and samples f into a 16-bit truth table.
It compares the result bit-by-bit against an expected table and reports pass/fail plus a mismatch count.
It replaces hand-written exhaustive stimulus with a reusable, synthesizable checker stage placed directly around the function block.

---
 rtl/minterm_sweeper_pkg.sv | 16 +
 rtl/settle_timer.sv | 29 ++
 rtl/minterm_sweeper.sv | 95 +++++++++
 tb/tb_minterm_sweeper.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/minterm_sweeper_pkg.sv
// Shared definitions for the minterm sweep checker: state encoding and sweep geometry.
// Latency: n/a (definitions only); backpressure: n/a.
package minterm_sweeper_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NUM_MINTERMS = 16;
  localparam int IDX_W        = 4;
  // Wide enough for the largest legal settle window (15).
  localparam int CNT_W        = 4;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures the hold window of each minterm; zero marks the sample edge.
// Latency: load takes effect on the next edge; backpressure: none.
module settle_timer
  import minterm_sweeper_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(SETTLE - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/minterm_sweeper.sv
// Drives all 16 minterms onto a 4-input function block, captures f into a truth table and scores it.
// Latency: 16*SETTLE cycles from start to done; backpressure: none, start is ignored while busy.
module minterm_sweeper
  import minterm_sweeper_pkg::*;
#(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic        x4,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  mismatch_cnt,
  output logic        pass
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             launch;
  logic             sample;
  logic             last;
  logic             miss;
  logic             tmr_load;
  logic             tmr_zero;
  logic [4:0]       cnt_nxt;

  assign launch   = start && (state != S_RUN);
  assign sample   = (state == S_RUN) && tmr_zero;
  assign last     = (idx == IDX_W'(NUM_MINTERMS - 1));
  assign miss     = (f != EXPECTED[idx]);
  assign cnt_nxt  = mismatch_cnt + {4'd0, miss};
  assign tmr_load = launch || (sample && !last);

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (state == S_RUN),
    .zero (tmr_zero)
  );

  // The index register is the driven minterm, so x changes on the same edge as the sample.
  assign {x1, x2, x3, x4} = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tt           <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            state        <= S_RUN;
            idx          <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            tt           <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
          end
        end
        S_RUN: begin
          if (sample) begin
            tt[idx]      <= f;
            mismatch_cnt <= cnt_nxt;
            if (last) begin
              state <= S_DONE;
              idx   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Uses the count including this final sample.
              pass  <= (cnt_nxt == 5'd0);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_sweeper.sv
// Bench for minterm_sweeper: four instances with different SETTLE/EXPECTED, a timeline model,
// directed scenarios and a randomized phase.
module tb_minterm_sweeper;

  localparam int N = 4;
  localparam int ST [N] = '{2, 2, 1, 3};
  localparam logic [15:0] EX [N] = '{16'hAAAA, 16'hFFFF, 16'h0FF0, 16'h5A3C};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a [N];
  logic        f_a     [N];
  logic        x1_a    [N];
  logic        x2_a    [N];
  logic        x3_a    [N];
  logic        x4_a    [N];
  logic        busy_a  [N];
  logic        done_a  [N];
  logic [15:0] tt_a    [N];
  logic [4:0]  mc_a    [N];
  logic        pass_a  [N];

  // Behaviour of each function block under sweep: f = ftab[minterm].
  logic [15:0] ftab [N];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : gen_dut
      assign f_a[g] = ftab[g][{x1_a[g], x2_a[g], x3_a[g], x4_a[g]}];
      minterm_sweeper #(.SETTLE(ST[g]), .EXPECTED(EX[g])) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start_a[g]),
        .f            (f_a[g]),
        .x1           (x1_a[g]),
        .x2           (x2_a[g]),
        .x3           (x3_a[g]),
        .x4           (x4_a[g]),
        .busy         (busy_a[g]),
        .done         (done_a[g]),
        .tt           (tt_a[g]),
        .mismatch_cnt (mc_a[g]),
        .pass         (pass_a[g])
      );
    end
  endgenerate

  // Timeline model: t counts edges since launch; minterm t/SETTLE is driven, sampled every SETTLE edges.
  bit          m_run  [N];
  int          m_t    [N];
  bit          m_done [N];
  logic [15:0] m_tt   [N];
  int          m_mc   [N];
  bit          m_pass [N];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 1'b0;
      m_t[i]    = 0;
      m_done[i] = 1'b0;
      m_tt[i]   = '0;
      m_mc[i]   = 0;
      m_pass[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int k;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (!m_run[i] && start_a[i]) begin
        m_run[i]  = 1'b1;
        m_t[i]    = 0;
        m_done[i] = 1'b0;
        m_tt[i]   = '0;
        m_mc[i]   = 0;
        m_pass[i] = 1'b0;
      end else if (m_run[i]) begin
        m_t[i]++;
        if (m_t[i] % ST[i] == 0) begin
          k = m_t[i] / ST[i] - 1;
          m_tt[i][k] = ftab[i][k];
          if (ftab[i][k] != EX[i][k]) m_mc[i]++;
          if (k == 15) begin
            m_run[i]  = 1'b0;
            m_done[i] = 1'b1;
            m_pass[i] = (m_mc[i] == 0);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] xe;
    for (int i = 0; i < N; i++) begin
      xe = m_run[i] ? 4'(m_t[i] / ST[i]) : 4'd0;
      chk("busy", i, 32'(busy_a[i]), 32'(m_run[i]));
      chk("done", i, 32'(done_a[i]), 32'(m_done[i]));
      chk("x",    i, 32'({x1_a[i], x2_a[i], x3_a[i], x4_a[i]}), 32'(xe));
      chk("tt",   i, 32'(tt_a[i]), 32'(m_tt[i]));
      chk("mcnt", i, 32'(mc_a[i]), 32'(m_mc[i]));
      chk("pass", i, 32'(pass_a[i]), 32'(m_pass[i]));
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check at the falling edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  int d0, d2;

  initial begin
    for (int i = 0; i < N; i++) begin
      start_a[i] = 1'b0;
      ftab[i]    = '0;
    end
    model_reset();
    @(negedge clk);
    compare_all();
    step();
    rst = 1'b0;
    step();

    // Loopback f=x4 on #0, f=0 on #1, f=x1^x2 with start held on #2.
    ftab[0] = 16'hAAAA;
    ftab[1] = 16'h0000;
    ftab[2] = 16'h0FF0;
    ftab[3] = 16'(($urandom));
    start_a[0] = 1'b1;
    start_a[1] = 1'b1;
    start_a[2] = 1'b1;
    step();
    start_a[0] = 1'b0;
    start_a[1] = 1'b0;
    d0 = -1;
    d2 = -1;
    for (int c = 1; c <= 40; c++) begin
      start_a[0] = (c == 5 || c == 20);
      step();
      if (done_a[0] && d0 < 0) d0 = c;
      if (done_a[2] && d2 < 0) begin
        d2 = c;
        chk("lit_tt_s1", 2, 32'(tt_a[2]), 32'h0FF0);
        chk("lit_pass_s1", 2, 32'(pass_a[2]), 32'd1);
      end
      if (d2 > 0 && c == d2 + 1) begin
        chk("lit_done_drop", 2, 32'(done_a[2]), 32'd0);
        chk("lit_restart_busy", 2, 32'(busy_a[2]), 32'd1);
      end
    end
    start_a[0] = 1'b0;
    start_a[2] = 1'b0;
    chk("lit_done_cycle", 0, 32'(d0), 32'd32);
    chk("lit_done_cycle_s1", 2, 32'(d2), 32'd16);
    chk("lit_tt", 0, 32'(tt_a[0]), 32'hAAAA);
    chk("lit_mcnt", 0, 32'(mc_a[0]), 32'd0);
    chk("lit_pass", 0, 32'(pass_a[0]), 32'd1);
    chk("lit_mcnt_nowrap", 1, 32'(mc_a[1]), 32'd16);
    chk("lit_pass_fail", 1, 32'(pass_a[1]), 32'd0);
    for (int c = 0; c < 20; c++) step();

    // f tied high against 0xAAAA.
    ftab[0] = 16'hFFFF;
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    for (int c = 0; c < 34; c++) step();
    chk("lit_tt_ones", 0, 32'(tt_a[0]), 32'hFFFF);
    chk("lit_mcnt8", 0, 32'(mc_a[0]), 32'd8);
    chk("lit_pass8", 0, 32'(pass_a[0]), 32'd0);

    // Reset ten cycles into a sweep; outputs must clear before any edge.
    ftab[0] = 16'hAAAA;
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    for (int c = 0; c < 10; c++) step();
    start_a[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk("lit_rst_busy", 0, 32'(busy_a[0]), 32'd0);
    chk("lit_rst_x", 0, 32'({x1_a[0], x2_a[0], x3_a[0], x4_a[0]}), 32'd0);
    chk("lit_rst_tt", 0, 32'(tt_a[0]), 32'd0);
    chk("lit_rst_mcnt", 0, 32'(mc_a[0]), 32'd0);
    chk("lit_rst_done_pass", 0, 32'({done_a[0], pass_a[0]}), 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    start_a[0] = 1'b0;
    step();
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    d0 = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (done_a[0] && d0 < 0) d0 = c;
    end
    chk("lit_fresh_cycle", 0, 32'(d0), 32'd32);
    chk("lit_fresh_tt", 0, 32'(tt_a[0]), 32'hAAAA);

    // Random phase: random function tables, start pulses (incl. while busy), rare async resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_run[i] && $urandom_range(0, 3) == 0) ftab[i] = 16'($urandom);
        start_a[i] = ($urandom_range(0, 5) == 0);
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
